ls_size_ctrl: RTL
=================

Name: ls_size_ctrl

Overview:
- Multicycle load/store size controller for the 32-bit CPU datapath.
- Sequences LB/LH/LW/SB/SH/SW memory accesses.
- For loads: selects the byte or halfword from the memory word, drives it into the 16-or-8-to-32 sign extender (selector 0 = 16-bit input, 1 = 8-bit input), and raises the register-write strobe.
- For SB/SH: performs read-modify-write so the other bytes of the word are kept.

Parameters:
- MEM_LAT, 1, memory read latency in cycles (range 1..7); mem_rdata is valid MEM_LAT cycles after the first mem_read cycle.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  3  000 LB, 001 LH, 010 LW, 100 SB, 101 SH, 110 SW; other codes illegal
- byte_off  in  2  address bits [1:0]
- store_data  in  32  register value to store (low byte/halfword used for SB/SH)
- mem_rdata  in  32  memory read word
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_wdata  out  32  memory write word
- ext_sel  out  1  extender selector: 1 = 8-bit, 0 = 16-bit
- ext_in16  out  16  halfword to extender
- ext_in8  out  8  byte to extender
- word_sel  out  1  1 = register-write mux takes load_raw instead of extender output
- load_raw  out  32  captured memory word
- reg_write  out  1  register-file write strobe
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal/misaligned pulse

Behaviour:
- All outputs are registered. On reset assertion every output and all internal registers go to 0 immediately and the state is IDLE; this applies mid-operation too, with no memory write completed afterwards.
- Little-endian lanes:
  - byte_off 0 selects bits [7:0], 1 selects [15:8], 2 selects [23:16], 3 selects [31:24].
  - Halfword byte_off 0 selects [15:0]; byte_off 2 selects [31:16].
- Misaligned requests: LH/SH with byte_off[0]=1, and LW/SW with byte_off != 0.
- States: IDLE, RD, CAP, EXT, MRG, WR, ERR.
- IDLE:
  - When start=1, latch op, byte_off and store_data.
  - Illegal or misaligned request goes to ERR.
  - SW goes to WR.
  - All other legal ops go to RD.
  - start=0 stays in IDLE.
- RD:
  - mem_read=1 for exactly MEM_LAT cycles, counted with a down-counter loaded with MEM_LAT-1; then go to CAP.
- CAP:
  - mem_read=0. Latch mem_rdata into load_raw.
  - Loads go to EXT; SB/SH go to MRG.
- EXT (1 cycle):
  - ext_sel=1 for LB, 0 for LH.
  - ext_in8 / ext_in16 carry the selected lane.
  - word_sel=1 only for LW.
  - reg_write=1, done=1; then go to IDLE.
- MRG (1 cycle):
  - mem_wdata = load_raw with the selected lane replaced by store_data[7:0] (SB) or store_data[15:0] (SH).
  - Then go to WR.
- WR (1 cycle):
  - mem_write=1, done=1.
  - mem_wdata = store_data for SW, otherwise the merged word.
  - Then go to IDLE.
- ERR (1 cycle):
  - err=1 with no memory access and no reg_write; then go to IDLE.
- Holding values: ext_in8, ext_in16, ext_sel, word_sel and load_raw hold their values after EXT until the next CAP or EXT. mem_wdata holds until the next MRG or WR.
- Latency, counted from the start-accept edge to the done cycle:
  - LW/LH/LB: MEM_LAT+2 cycles.
  - SB/SH: MEM_LAT+3 cycles.
  - SW: 1 cycle.
  - ERR: 1 cycle.
- Back-to-back: a start held high while busy is ignored. A new request is accepted in the IDLE cycle right after done or err, so there is no dead cycle beyond IDLE.

Test Plan:
- LB, byte_off=1, mem_rdata=32'h0000_F400, MEM_LAT=1:
  - mem_read high 1 cycle.
  - EXT cycle shows ext_sel=1, ext_in8=8'hF4, reg_write=1, done=1, 3 cycles after the start edge.
  - The extender then yields 32'hFFFF_FFF4.
- LH, byte_off=2, mem_rdata=32'h0004_1234:
  - ext_sel=0, ext_in16=16'h0004, word_sel=0.
  - Repeat with 32'hFFFC_0000: ext_in16=16'hFFFC, extender yields 32'hFFFF_FFFC.
- SB, byte_off=3, store_data=32'h0000_00AB, mem_rdata=32'h1122_3344:
  - Single mem_write pulse with mem_wdata=32'hAB22_3344.
  - done arrives MEM_LAT+3 cycles after start; reg_write never asserted.
- SW, byte_off=0, store_data=32'hDEAD_BEEF: next cycle mem_write=1, mem_wdata=32'hDEAD_BEEF, done=1, mem_read never high.
- Error cases:
  - LW with byte_off=2 gives err=1 for 1 cycle, with no mem_read, mem_write or reg_write.
  - op=3'b011 gives the same.
- Reset and busy handling:
  - Assert reset during the RD state of an SH: all outputs drop to 0 asynchronously and no mem_write follows.
  - Rerun with MEM_LAT=3: mem_read stays high exactly 3 cycles.
  - start pulses while busy are ignored.

Source files
------------

// File: rtl/ls_size_ctrl.sv
// Load/store size controller: sequences LB/LH/LW/SB/SH/SW through a
// multicycle memory port. Sub-word stores use read-modify-write.
// All outputs are registered against the next state.
module ls_size_ctrl #(
   parameter int MEM_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [1:0]  byte_off,
   input  logic [31:0] store_data,
   input  logic [31:0] mem_rdata,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   output logic        ext_sel,
   output logic [15:0] ext_in16,
   output logic [7:0]  ext_in8,
   output logic        word_sel,
   output logic [31:0] load_raw,
   output logic        reg_write,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, RD, CAP, EXT, MRG, WR, ERR} state_t;

   localparam logic [2:0] OP_LB = 3'b000;
   localparam logic [2:0] OP_LH = 3'b001;
   localparam logic [2:0] OP_LW = 3'b010;
   localparam logic [2:0] OP_SB = 3'b100;
   localparam logic [2:0] OP_SH = 3'b101;
   localparam logic [2:0] OP_SW = 3'b110;

   state_t      state, nxt;
   logic [2:0]  op_q;
   logic [1:0]  off_q;
   logic [31:0] sd_q;
   logic [2:0]  cnt;
   logic        bad_req;

   // Little-endian byte lane pick
   function automatic logic [7:0] sel8(input logic [31:0] w, input logic [1:0] off);
      return w[{off, 3'b000} +: 8];
   endfunction

   // Halfword lane pick: only off[1] matters for aligned halfwords
   function automatic logic [15:0] sel16(input logic [31:0] w, input logic [1:0] off);
      return off[1] ? w[31:16] : w[15:0];
   endfunction

   // Replace the addressed lane of w with the low byte/halfword of sd
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [1:0] off,
                                         input logic [31:0] sd, input logic half);
      logic [31:0] r;
      r = w;
      if (half) begin
         if (off[1]) r[31:16] = sd[15:0];
         else        r[15:0]  = sd[15:0];
      end else begin
         r[{off, 3'b000} +: 8] = sd[7:0];
      end
      return r;
   endfunction

   // Illegal opcode or misaligned address for the requested size
   always_comb begin
      bad_req = 1'b0;
      case (op)
         OP_LB, OP_SB: bad_req = 1'b0;
         OP_LH, OP_SH: bad_req = byte_off[0];
         OP_LW, OP_SW: bad_req = |byte_off;
         default:      bad_req = 1'b1;
      endcase
   end

   // Next-state logic
   always_comb begin
      nxt = state;
      case (state)
         IDLE: if (start) begin
            if (bad_req)           nxt = ERR;
            else if (op == OP_SW)  nxt = WR;
            else                   nxt = RD;
         end
         RD:   if (cnt == 3'd0) nxt = CAP;
         CAP:  nxt = op_q[2] ? MRG : EXT;
         MRG:  nxt = WR;
         EXT, WR, ERR: nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // State register and read-latency down-counter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= nxt;
         if (state == IDLE)                cnt <= 3'(MEM_LAT - 1);
         else if (state == RD && cnt != 0) cnt <= cnt - 3'd1;
      end
   end

   // Request latch and registered outputs, driven from the state being entered
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= 3'd0;
         off_q     <= 2'd0;
         sd_q      <= 32'd0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_wdata <= 32'd0;
         ext_sel   <= 1'b0;
         ext_in16  <= 16'd0;
         ext_in8   <= 8'd0;
         word_sel  <= 1'b0;
         load_raw  <= 32'd0;
         reg_write <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_read  <= (nxt == RD);
         mem_write <= (nxt == WR);
         reg_write <= (nxt == EXT);
         busy      <= (nxt != IDLE);
         done      <= (nxt == EXT) || (nxt == WR);
         err       <= (nxt == ERR);
         if (state == IDLE && start) begin
            op_q  <= op;
            off_q <= byte_off;
            sd_q  <= store_data;
            if (nxt == WR) mem_wdata <= store_data;
         end
         if (state == CAP) begin
            load_raw <= mem_rdata;
            if (op_q[2]) begin
               mem_wdata <= merge(mem_rdata, off_q, sd_q, op_q[0]);
            end else begin
               ext_sel  <= (op_q == OP_LB);
               ext_in8  <= sel8(mem_rdata, off_q);
               ext_in16 <= sel16(mem_rdata, off_q);
               word_sel <= (op_q == OP_LW);
            end
         end
      end
   end

endmodule
